stream_decoder: RTL and testbench
=================================

# stream_decoder

Handshaked instruction-stream decoder for the Bully core, the parametrised successor to `decoder`. It accepts a stream of BUS_WIDTH words (a header word followed by 0, 1 or 2 operand words, depending on type and opcode) over a valid/ready interface, checks type, opcode and privilege, and presents one complete command per output handshake. It sits between instruction fetch and execute, and it back-pressures fetch while a decoded command is waiting.

## Interface
Parameters:
- BUS_WIDTH, 32, width of data words; the header is {admin, type[2:0], opcode[BUS_WIDTH-5:0]}
- USER_INT, 0, when 1, INT-type headers are legal with admin=0

Ports:
- clk  in  1  clock; all logic on rising edge
- nreset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous abort of any partial or held command
- data_in  in  BUS_WIDTH  header or operand word
- in_valid  in  1  data_in valid
- in_ready  out  1  word accepted when in_valid & in_ready
- admin_flag  out  1  decoded header bit BUS_WIDTH-1
- code_type  out  3  decoded header bits BUS_WIDTH-2:BUS_WIDTH-4
- opcode  out  BUS_WIDTH-4  decoded header low bits
- opdata0  out  BUS_WIDTH  first operand (0 if none)
- opdata1  out  BUS_WIDTH  second operand (0 if none)
- out_valid  out  1  command fields valid
- out_ready  in  1  consumer takes command when out_valid & out_ready
- decoder_error  out  1  one-cycle error pulse
- error_code  out  2  1 illegal type, 2 illegal opcode, 3 privilege; held until the next error or reset

## Operation
- Type encodings: CTL 111, INT 000, REG 001, IMM 010, JMP 100. Types 011, 101 and 110 are illegal.
- Legal opcodes and operand counts:
  - CTL: opcode 0 (HLT), 0 operands.
  - INT: any opcode (vector), 0 operands.
  - REG and IMM: opcodes 0–6 (MOV, ADD, SUB, AND, OR, XOR, CMP), 2 operands.
  - JMP: opcodes 0–4 (JMP, JE, JG, SJF, SJB), 1 operand.
- Privilege rules:
  - CTL requires admin=1.
  - INT requires admin=1 unless USER_INT=1.
  - Privilege is checked after type and opcode, so only one error code is reported per header.
- FSM states: IDLE, OP0, OP1, HOLD.
  - IDLE, legal header accepted: latch the header fields and clear opdata0/opdata1. Go to HOLD (0 operands) or OP0.
  - IDLE, bad header accepted: pulse decoder_error, load error_code, stay in IDLE. The word is discarded; no operands are consumed.
  - OP0, word accepted: latch opdata0. Go to OP1 (2-operand command) or HOLD.
  - OP1, word accepted: latch opdata1. Go to HOLD.
  - HOLD: out_valid=1. When out_ready=1, go to IDLE.
- in_ready = 1 in IDLE, OP0 and OP1; 0 in HOLD.
- Output fields stay stable while out_valid=1.
- flush=1: next state is IDLE, out_valid drops, the partial command is discarded, and no error is raised. flush overrides every other event in the same cycle, including an input or output handshake.
- Reset values: state IDLE, in_ready=1, out_valid=0, decoder_error=0, error_code=0, and all field outputs 0.

## Timing
- Header accepted at edge N with a 0-operand command: out_valid=1 after edge N.
- k-operand command: out_valid=1 after the edge that accepts the last operand.
- Minimum period per command is k+2 cycles, because HOLD blocks input for at least one cycle.
- decoder_error is high for exactly the cycle after the bad header is accepted. A legal header may be accepted in that same cycle.
- Asynchronous reset mid-command: outputs clear immediately and the partial command is lost.
- in_valid=0 in OP0 or OP1: the FSM waits indefinitely with no timeout.
- out_ready is ignored unless out_valid=1.

## Test plan
- IMM ADD, admin=0, header then operands 1 and 4, out_ready=1 → out_valid pulses one cycle with code_type=010, opcode=1, opdata0=1, opdata1=4, and decoder_error stays 0.
- INT vector 1, admin=1, then JMP JG, admin=1, operand 2 → INT is presented with opdata0=0 and opdata1=0 one cycle after acceptance. JG is presented with opdata0=2 and opdata1=0.
- Header with type 101, opcode 4, followed by word 0 → decoder_error=1 for one cycle with error_code=1. Word 0 is then parsed as a header (INT, admin=0): with USER_INT=0 this gives error_code=3; with USER_INT=1 it is presented as INT.
- REG opcode 7 → error_code=2. CTL HLT with admin=0 → error_code=3. CTL HLT with admin=1 → presented normally.
- Back-pressure: out_ready=0 for 5 cycles during a REG command → in_ready=0 throughout and fields stable. When out_ready rises, the command is taken and in_ready returns to 1 the next cycle.
- flush asserted in OP0, and again during HOLD → state returns to IDLE, out_valid=0, and no error is raised. A following IMM command decodes correctly. Repeat the scenario with nreset pulsed low mid-command → all outputs 0 and in_ready=1.

Source files
------------

// File: rtl/stream_decoder.sv
// -----------------------------------------------------------------------------
// stream_decoder
//
// Handshaked instruction-stream decoder. Accepts a header word followed by
// 0, 1 or 2 operand words over a valid/ready input, validates type, opcode and
// privilege, and presents one complete command per output handshake.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where valid & ready are both 1. The producer keeps data stable while valid
// is high and not yet taken; ready may depend on state only, never on valid.
//
// Header layout: {admin, type[2:0], opcode[BUS_WIDTH-5:0]}
//
// Ports:
//   clk            clock, rising edge
//   nreset         asynchronous active-low reset
//   flush          synchronous abort of any partial or held command
//   data_in        header or operand word
//   in_valid       data_in valid
//   in_ready       decoder can accept a word (low only while holding a command)
//   admin_flag     decoded header admin bit
//   code_type      decoded header type
//   opcode         decoded header opcode
//   opdata0        first operand (0 if none)
//   opdata1        second operand (0 if none)
//   out_valid      command fields valid
//   out_ready      consumer takes command when out_valid & out_ready
//   decoder_error  one-cycle error pulse
//   error_code     1 illegal type, 2 illegal opcode, 3 privilege; sticky
//   dbg_state      current FSM state (0 IDLE, 1 OP0, 2 OP1, 3 HOLD)
// -----------------------------------------------------------------------------
module stream_decoder #(
    parameter int BUS_WIDTH = 32,
    parameter int USER_INT  = 0
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 flush,
    input  logic [BUS_WIDTH-1:0] data_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 admin_flag,
    output logic [2:0]           code_type,
    output logic [BUS_WIDTH-5:0] opcode,
    output logic [BUS_WIDTH-1:0] opdata0,
    output logic [BUS_WIDTH-1:0] opdata1,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 decoder_error,
    output logic [1:0]           error_code,
    output logic [1:0]           dbg_state
);

    localparam int OPW = BUS_WIDTH - 4;

    localparam logic [2:0] TYPE_CTL = 3'b111;
    localparam logic [2:0] TYPE_INT = 3'b000;
    localparam logic [2:0] TYPE_REG = 3'b001;
    localparam logic [2:0] TYPE_IMM = 3'b010;
    localparam logic [2:0] TYPE_JMP = 3'b100;

    localparam logic [1:0] ERR_TYPE = 2'd1;
    localparam logic [1:0] ERR_OPC  = 2'd2;
    localparam logic [1:0] ERR_PRIV = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OP0  = 2'd1,
        S_OP1  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 admin_q, admin_d;
    logic [2:0]           type_q, type_d;
    logic [OPW-1:0]       opcode_q, opcode_d;
    logic [BUS_WIDTH-1:0] op0_q, op0_d;
    logic [BUS_WIDTH-1:0] op1_q, op1_d;
    logic                 two_ops_q, two_ops_d;
    logic                 derr_q, derr_d;
    logic [1:0]           ecode_q, ecode_d;

    // Header field view of the incoming word (only meaningful in IDLE).
    logic           hdr_admin;
    logic [2:0]     hdr_type;
    logic [OPW-1:0] hdr_opcode;
    logic [1:0]     hdr_err;
    logic [1:0]     hdr_nops;
    logic           accept;

    assign hdr_admin  = data_in[BUS_WIDTH-1];
    assign hdr_type   = data_in[BUS_WIDTH-2 -: 3];
    assign hdr_opcode = data_in[OPW-1:0];

    // Header classification. Type is checked first, then opcode, then
    // privilege, so each bad header reports exactly one error code.
    always_comb begin
        hdr_err  = 2'd0;
        hdr_nops = 2'd0;
        unique case (hdr_type)
            TYPE_CTL: begin
                if (hdr_opcode != '0)  hdr_err = ERR_OPC;
                else if (!hdr_admin)   hdr_err = ERR_PRIV;
            end
            TYPE_INT: begin
                if (!hdr_admin && (USER_INT == 0)) hdr_err = ERR_PRIV;
            end
            TYPE_REG, TYPE_IMM: begin
                hdr_nops = 2'd2;
                if (hdr_opcode > OPW'(6)) hdr_err = ERR_OPC;
            end
            TYPE_JMP: begin
                hdr_nops = 2'd1;
                if (hdr_opcode > OPW'(4)) hdr_err = ERR_OPC;
            end
            default: hdr_err = ERR_TYPE;
        endcase
    end

    assign in_ready = (state_q != S_HOLD);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        admin_d   = admin_q;
        type_d    = type_q;
        opcode_d  = opcode_q;
        op0_d     = op0_q;
        op1_d     = op1_q;
        two_ops_d = two_ops_q;
        derr_d    = 1'b0;
        ecode_d   = ecode_q;

        if (flush) begin
            // Abort wins over any handshake in the same cycle; no error raised.
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (hdr_err != 2'd0) begin
                            derr_d  = 1'b1;
                            ecode_d = hdr_err;
                        end else begin
                            admin_d   = hdr_admin;
                            type_d    = hdr_type;
                            opcode_d  = hdr_opcode;
                            op0_d     = '0;
                            op1_d     = '0;
                            two_ops_d = (hdr_nops == 2'd2);
                            state_d   = (hdr_nops == 2'd0) ? S_HOLD : S_OP0;
                        end
                    end
                end
                S_OP0: begin
                    if (accept) begin
                        op0_d   = data_in;
                        state_d = two_ops_q ? S_OP1 : S_HOLD;
                    end
                end
                S_OP1: begin
                    if (accept) begin
                        op1_d   = data_in;
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= S_IDLE;
            admin_q   <= 1'b0;
            type_q    <= 3'b000;
            opcode_q  <= '0;
            op0_q     <= '0;
            op1_q     <= '0;
            two_ops_q <= 1'b0;
            derr_q    <= 1'b0;
            ecode_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            admin_q   <= admin_d;
            type_q    <= type_d;
            opcode_q  <= opcode_d;
            op0_q     <= op0_d;
            op1_q     <= op1_d;
            two_ops_q <= two_ops_d;
            derr_q    <= derr_d;
            ecode_q   <= ecode_d;
        end
    end

    assign out_valid     = (state_q == S_HOLD);
    assign admin_flag    = admin_q;
    assign code_type     = type_q;
    assign opcode        = opcode_q;
    assign opdata0       = op0_q;
    assign opdata1       = op1_q;
    assign decoder_error = derr_q;
    assign error_code    = ecode_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_stream_decoder.sv
// -----------------------------------------------------------------------------
// tb_stream_decoder
//
// Two decoders (USER_INT=0 and USER_INT=1) share one input stream. A word-level
// model per instance tracks the command being assembled as a header plus a
// list of collected operands; outputs are compared every cycle on the falling
// edge. Directed scenarios with literal expectations come first, then random.
// -----------------------------------------------------------------------------
module tb_stream_decoder;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         nreset;
  logic         flush;
  logic [W-1:0] data_in;
  logic         in_valid;
  logic         out_ready;

  logic         in_ready_w [2];
  logic         admin_w    [2];
  logic [2:0]   type_w     [2];
  logic [W-5:0] opc_w      [2];
  logic [W-1:0] op0_w      [2];
  logic [W-1:0] op1_w      [2];
  logic         ov_w       [2];
  logic         derr_w     [2];
  logic [1:0]   ec_w       [2];
  logic [1:0]   st_w       [2];

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------- clock/reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  stream_decoder #(.BUS_WIDTH(W), .USER_INT(0)) dut0 (
    .clk(clk), .nreset(nreset), .flush(flush), .data_in(data_in),
    .in_valid(in_valid), .in_ready(in_ready_w[0]), .admin_flag(admin_w[0]),
    .code_type(type_w[0]), .opcode(opc_w[0]), .opdata0(op0_w[0]),
    .opdata1(op1_w[0]), .out_valid(ov_w[0]), .out_ready(out_ready),
    .decoder_error(derr_w[0]), .error_code(ec_w[0]), .dbg_state(st_w[0])
  );

  stream_decoder #(.BUS_WIDTH(W), .USER_INT(1)) dut1 (
    .clk(clk), .nreset(nreset), .flush(flush), .data_in(data_in),
    .in_valid(in_valid), .in_ready(in_ready_w[1]), .admin_flag(admin_w[1]),
    .code_type(type_w[1]), .opcode(opc_w[1]), .opdata0(op0_w[1]),
    .opdata1(op1_w[1]), .out_valid(ov_w[1]), .out_ready(out_ready),
    .decoder_error(derr_w[1]), .error_code(ec_w[1]), .dbg_state(st_w[1])
  );

  // ---------------------------------------------------------------- model
  bit           m_held   [2];
  bit           m_in_cmd [2];
  int           m_need   [2];
  int           m_got    [2];
  logic [W-1:0] m_hdr    [2];
  logic [W-1:0] m_op0    [2];
  logic [W-1:0] m_op1    [2];
  bit           m_err    [2];
  logic [1:0]   m_code   [2];

  function automatic logic [W-1:0] hdr(input bit adm, input logic [2:0] t, input int op);
    logic [W-5:0] o;
    o = (W-4)'(op);
    return {adm, t, o};
  endfunction

  // Returns 0 for a legal header (nops = operand count) or the error code.
  function automatic logic [1:0] classify(input logic [W-1:0] w, input bit user_int,
                                          output int nops);
    logic       adm;
    logic [2:0] t;
    int         op;
    adm  = w[W-1];
    t    = w[W-2 -: 3];
    op   = int'(w[W-5:0]);
    nops = 0;
    case (t)
      3'b111: begin
        if (op != 0) return 2'd2;
        if (!adm) return 2'd3;
      end
      3'b000: if (!adm && !user_int) return 2'd3;
      3'b001, 3'b010: begin
        nops = 2;
        if (op < 0 || op > 6) return 2'd2;
      end
      3'b100: begin
        nops = 1;
        if (op < 0 || op > 4) return 2'd2;
      end
      default: return 2'd1;
    endcase
    return 2'd0;
  endfunction

  task automatic model_reset(input int u);
    m_held[u] = 0; m_in_cmd[u] = 0; m_need[u] = 0; m_got[u] = 0;
    m_hdr[u] = '0; m_op0[u] = '0; m_op1[u] = '0;
    m_err[u] = 0; m_code[u] = 2'd0;
  endtask

  task automatic model_update(input int u);
    logic [1:0] c;
    int         n;
    if (!nreset) begin
      model_reset(u);
      return;
    end
    m_err[u] = 0;
    if (flush) begin
      m_in_cmd[u] = 0;
      m_held[u]   = 0;
    end else if (m_held[u]) begin
      if (out_ready) m_held[u] = 0;
    end else if (in_valid) begin
      if (!m_in_cmd[u]) begin
        c = classify(data_in, (u == 1), n);
        if (c != 2'd0) begin
          m_err[u]  = 1;
          m_code[u] = c;
        end else begin
          m_hdr[u]  = data_in;
          m_op0[u]  = '0;
          m_op1[u]  = '0;
          m_need[u] = n;
          m_got[u]  = 0;
          if (n == 0) m_held[u] = 1;
          else m_in_cmd[u] = 1;
        end
      end else begin
        if (m_got[u] == 0) m_op0[u] = data_in;
        else m_op1[u] = data_in;
        m_got[u]++;
        if (m_got[u] == m_need[u]) begin
          m_held[u]   = 1;
          m_in_cmd[u] = 0;
        end
      end
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare(input int u);
    check($sformatf("u%0d.in_ready", u), 64'(in_ready_w[u]), 64'(!m_held[u]));
    check($sformatf("u%0d.out_valid", u), 64'(ov_w[u]), 64'(m_held[u]));
    check($sformatf("u%0d.decoder_error", u), 64'(derr_w[u]), 64'(m_err[u]));
    check($sformatf("u%0d.error_code", u), 64'(ec_w[u]), 64'(m_code[u]));
    if (m_held[u]) begin
      check($sformatf("u%0d.admin_flag", u), 64'(admin_w[u]), 64'(m_hdr[u][W-1]));
      check($sformatf("u%0d.code_type", u), 64'(type_w[u]), 64'(m_hdr[u][W-2 -: 3]));
      check($sformatf("u%0d.opcode", u), 64'(opc_w[u]), 64'(m_hdr[u][W-5:0]));
      check($sformatf("u%0d.opdata0", u), 64'(op0_w[u]), 64'(m_op0[u]));
      check($sformatf("u%0d.opdata1", u), 64'(op1_w[u]), 64'(m_op1[u]));
    end
  endtask

  // One clock: model advances on the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_update(0);
    model_update(1);
    @(negedge clk);
    compare(0);
    compare(1);
  endtask

  // ---------------------------------------------------------------- driver
  task automatic send(input logic [W-1:0] w);
    int n;
    n = 0;
    while (!in_ready_w[0] && n < 20) begin
      step();
      n++;
    end
    if (!in_ready_w[0]) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 after %0d cycles", n);
    end
    in_valid = 1'b1;
    data_in  = w;
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_zero_outputs(input int u);
    check($sformatf("u%0d.rst_in_ready", u), 64'(in_ready_w[u]), 64'd1);
    check($sformatf("u%0d.rst_out_valid", u), 64'(ov_w[u]), 64'd0);
    check($sformatf("u%0d.rst_decoder_error", u), 64'(derr_w[u]), 64'd0);
    check($sformatf("u%0d.rst_error_code", u), 64'(ec_w[u]), 64'd0);
    check($sformatf("u%0d.rst_fields", u),
          64'({admin_w[u], type_w[u], opc_w[u]}) | 64'(op0_w[u]) | 64'(op1_w[u]), 64'd0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    nreset    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    model_reset(0);
    model_reset(1);
    #2;
    check_zero_outputs(0);
    check_zero_outputs(1);
    @(negedge clk);
    step();
    nreset = 1'b1;
    step();

    // IMM ADD, admin=0, operands 1 and 4
    out_ready = 1'b1;
    send(hdr(0, 3'b010, 1));
    send(32'd1);
    send(32'd4);
    check("imm.out_valid", 64'(ov_w[0]), 64'd1);
    check("imm.code_type", 64'(type_w[0]), 64'd2);
    check("imm.opcode", 64'(opc_w[0]), 64'd1);
    check("imm.opdata0", 64'(op0_w[0]), 64'd1);
    check("imm.opdata1", 64'(op1_w[0]), 64'd4);
    check("imm.decoder_error", 64'(derr_w[0]), 64'd0);
    step();
    check("imm.out_valid_pulse", 64'(ov_w[0]), 64'd0);

    // INT vector 1 admin=1, then JMP JG operand 2
    send(hdr(1, 3'b000, 1));
    check("int.out_valid", 64'(ov_w[0]), 64'd1);
    check("int.opdata0", 64'(op0_w[0]), 64'd0);
    check("int.opdata1", 64'(op1_w[0]), 64'd0);
    step();
    send(hdr(1, 3'b100, 2));
    send(32'd2);
    check("jg.out_valid", 64'(ov_w[0]), 64'd1);
    check("jg.code_type", 64'(type_w[0]), 64'd4);
    check("jg.opdata0", 64'(op0_w[0]), 64'd2);
    check("jg.opdata1", 64'(op1_w[0]), 64'd0);
    step();

    // Illegal type 101, then word 0 parsed as INT admin=0
    send(hdr(0, 3'b101, 4));
    check("badtype.u0.err", 64'(derr_w[0]), 64'd1);
    check("badtype.u0.code", 64'(ec_w[0]), 64'd1);
    check("badtype.u1.code", 64'(ec_w[1]), 64'd1);
    send('0);
    check("userint0.err", 64'(derr_w[0]), 64'd1);
    check("userint0.code", 64'(ec_w[0]), 64'd3);
    check("userint1.out_valid", 64'(ov_w[1]), 64'd1);
    check("userint1.code_type", 64'(type_w[1]), 64'd0);
    step();
    check("userint0.err_drop", 64'(derr_w[0]), 64'd0);

    // Opcode and privilege errors, then legal HLT
    send(hdr(0, 3'b001, 7));
    check("regop7.code", 64'(ec_w[0]), 64'd2);
    send(hdr(0, 3'b111, 0));
    check("hlt_user.code", 64'(ec_w[0]), 64'd3);
    send(hdr(1, 3'b111, 0));
    check("hlt_admin.out_valid", 64'(ov_w[0]), 64'd1);
    check("hlt_admin.code_type", 64'(type_w[0]), 64'd7);
    check("hlt_admin.err", 64'(derr_w[0]), 64'd0);
    step();

    // Back-pressure on a REG command
    out_ready = 1'b0;
    send(hdr(0, 3'b001, 2));
    send(32'd5);
    send(32'd6);
    for (int i = 0; i < 5; i++) begin
      check("bp.in_ready", 64'(in_ready_w[0]), 64'd0);
      check("bp.out_valid", 64'(ov_w[0]), 64'd1);
      check("bp.opdata0", 64'(op0_w[0]), 64'd5);
      check("bp.opdata1", 64'(op1_w[0]), 64'd6);
      step();
    end
    out_ready = 1'b1;
    step();
    check("bp.release_out_valid", 64'(ov_w[0]), 64'd0);
    check("bp.release_in_ready", 64'(in_ready_w[0]), 64'd1);

    // flush in OP0 (with a competing input handshake), then in HOLD
    send(hdr(0, 3'b010, 3));
    flush    = 1'b1;
    in_valid = 1'b1;
    data_in  = 32'd9;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_op0.out_valid", 64'(ov_w[0]), 64'd0);
    check("flush_op0.in_ready", 64'(in_ready_w[0]), 64'd1);
    check("flush_op0.err", 64'(derr_w[0]), 64'd0);
    out_ready = 1'b0;
    send(hdr(0, 3'b001, 0));
    send(32'd1);
    send(32'd2);
    flush = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    check("flush_hold.out_valid", 64'(ov_w[0]), 64'd0);
    check("flush_hold.err", 64'(derr_w[0]), 64'd0);
    send(hdr(0, 3'b010, 4));
    send(32'd7);
    send(32'd8);
    check("post_flush.opcode", 64'(opc_w[0]), 64'd4);
    check("post_flush.opdata0", 64'(op0_w[0]), 64'd7);
    check("post_flush.opdata1", 64'(op1_w[0]), 64'd8);
    step();

    // Asynchronous reset mid-command
    send(hdr(0, 3'b001, 1));
    send(32'd3);
    nreset = 1'b0;
    #1;
    check_zero_outputs(0);
    check_zero_outputs(1);
    step();
    nreset = 1'b1;
    step();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      nreset    = ($urandom_range(0, 499) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 1) == 0)
        data_in = hdr($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
                      $urandom_range(0, 8));
      else
        data_in = $urandom;
      step();
    end
    nreset   = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
